// File: rtl/seq_match_pkg.sv
// Shared types and defaults for the serial pattern-match scheduler.
package seq_match_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        REPORT
    } state_t;

    localparam int N_REQ_DEF   = 4;
    localparam int FRAME_W_DEF = 8;
    localparam int PAT_W_DEF   = 4;
    localparam int CNT_W_DEF   = 4;
    localparam int ID_W        = 2;

    // Largest possible match count for a frame (every window position hits).
    function automatic int max_match(input int frame_w, input int pat_w);
        return frame_w - pat_w + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter: first set request after ptr, with wrap.
// The wrap relies on N_REQ == 2**ID_W so the index arithmetic rolls over.
module rr_arbiter_n
    import seq_match_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    logic [ID_W-1:0] idx;

    // Scan ptr+1, ptr+2, ... and take the first requester found.
    always_comb begin
        // NOTE: every output gets a default before the search loop; without it
        // the no-request path would leave them unassigned and infer latches.
        grant = '0;
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr + ID_W'(k);
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                id         = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_match_scheduler.sv
// Arbitrates requesters onto one serial overlapping pattern detector and
// reports the per-frame match count.
module seq_match_scheduler
    import seq_match_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int PAT_W   = PAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*FRAME_W-1:0] frame_data,
    input  logic [PAT_W-1:0]         pattern,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     z,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [CNT_W-1:0]         match_count
);

    localparam int BIT_W = $clog2(FRAME_W + 1);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id_q;
    logic [FRAME_W-1:0] shift_reg;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   window;
    logic [BIT_W-1:0]   bits_seen;
    logic [CNT_W-1:0]   count;

    logic [N_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_valid;

    logic [FRAME_W-1:0] slots [N_REQ];
    logic [PAT_W-1:0]   window_nxt;
    logic               hit;
    logic               last_bit;

    rr_arbiter_n #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .id    (arb_id),
        .valid (arb_valid)
    );

    // Split the flat frame bus into per-requester slots.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slots[i] = frame_data[i*FRAME_W +: FRAME_W];
        end
    end

    // Next window and match decision; the bits_seen guard keeps the
    // reset-zero window from matching all-zero patterns early.
    always_comb begin
        window_nxt = {window[PAT_W-2:0], shift_reg[FRAME_W-1]};
        hit        = (window_nxt == pat_q) && (int'(bits_seen) + 1 >= PAT_W);
        last_bit   = (int'(bits_seen) == FRAME_W - 1);
    end

    // Scheduler FSM and datapath with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            shift_reg   <= '0;
            pat_q       <= '0;
            window      <= '0;
            bits_seen   <= '0;
            count       <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            z           <= 1'b0;
            done        <= 1'b0;
            done_id     <= '0;
            match_count <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every branch reads the
            // pre-edge values and the default pulse clears below are safe.
            grant <= '0;
            z     <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        id_q  <= arb_id;
                        grant <= arb_grant;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg <= slots[id_q];
                    pat_q     <= pattern;
                    window    <= '0;
                    bits_seen <= '0;
                    count     <= '0;
                    ptr       <= id_q;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    window    <= window_nxt;
                    shift_reg <= shift_reg << 1;
                    bits_seen <= bits_seen + BIT_W'(1);
                    z         <= hit;
                    if (hit) begin
                        count <= count + CNT_W'(1);
                    end
                    if (last_bit) begin
                        done        <= 1'b1;
                        done_id     <= id_q;
                        match_count <= count + CNT_W'(hit);
                        state       <= REPORT;
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
